// File: rtl/pixel_ram_writer.sv
// pixel_ram_writer: buffers pixel plot requests and writes them, or a full-frame clear sweep, to the frame RAM.
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_i              asynchronous active-low reset
//   plot_i             plot request strobe, accepted when plot_i && ready_o
//   x_i, y_i           pixel column / row
//   colour_i           pixel colour
//   ready_o            FIFO can accept a request this cycle
//   clear_i            clear-frame request pulse
//   busy_o             clear pending or running, or FIFO non-empty
//   wr_addr_o          RAM write address (y*WIDTH + x)
//   wr_data_o          RAM write data
//   wren_o             RAM write enable, one cycle per write
//   oob_err_o          sticky out-of-range flag (only with PIXEL_BOUNDS_CHECK_EN)
//
// Build option: define PIXEL_BOUNDS_CHECK_EN to drop out-of-range plots and flag them on oob_err_o.
module pixel_ram_writer #(
    parameter int          WIDTH        = 160,
    parameter int          HEIGHT       = 120,
    parameter int          ADDR_W       = 15,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              plot_i,
    input  logic [7:0]        x_i,
    input  logic [6:0]        y_i,
    input  logic [2:0]        colour_i,
    output logic              ready_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [2:0]        wr_data_o,
    output logic              wren_o
`ifdef PIXEL_BOUNDS_CHECK_EN
    ,
    output logic              oob_err_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    state_e             state_q, state_d;
    logic [17:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  sweep_q, sweep_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [2:0]         wr_data_d;
    logic               wren_d;
    logic               live_q;
    logic               push, pop, keep;
    logic [17:0]        head;
    logic [ADDR_W-1:0]  head_addr;

    // live_q holds ready low while in reset and until the first edge after release
    assign ready_o   = live_q && state_q == IDLE && cnt_q != CNT_W'(FIFO_DEPTH);
    assign busy_o    = state_q != IDLE || cnt_q != '0;
    assign push      = plot_i && ready_o;
    assign pop       = cnt_q != '0 && (state_q == IDLE || state_q == DRAIN);
    assign head      = mem_q[rd_ptr_q];
    assign head_addr = ADDR_W'(head[9:3]) * ADDR_W'(WIDTH) + ADDR_W'(head[17:10]);

`ifdef PIXEL_BOUNDS_CHECK_EN
    assign keep = head[17:10] < WIDTH && head[9:3] < HEIGHT;
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        wren_d    = pop && keep;
        wr_addr_d = pop ? head_addr : wr_addr_o;
        wr_data_d = pop ? head[2:0] : wr_data_o;
        unique case (state_q)
            IDLE:  state_d = clear_i ? DRAIN : IDLE;
            DRAIN: begin
                // pop implies a non-empty FIFO, so an empty count means no pop this cycle
                state_d = cnt_q == '0 ? CLEAR : DRAIN;
                sweep_d = '0;
            end
            CLEAR: begin
                wren_d    = 1'b1;
                wr_addr_d = sweep_q;
                wr_data_d = CLEAR_COLOUR;
                sweep_d   = sweep_q + 1'b1;
                state_d   = sweep_q == LAST ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            sweep_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            wren_o    <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            wr_ptr_q  <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q  <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            cnt_q     <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            wren_o    <= wren_d;
            wr_addr_o <= wr_addr_d;
            wr_data_o <= wr_data_d;
            live_q    <= 1'b1;
        end
    end

    // storage needs no reset: the pointers and count define which entries are valid
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= {x_i, y_i, colour_i};
    end

`ifdef PIXEL_BOUNDS_CHECK_EN
    // cleared on the DRAIN->CLEAR transition, i.e. as the sweep starts
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            oob_err_o <= 1'b0;
        else if (state_q == DRAIN && cnt_q == '0)
            oob_err_o <= 1'b0;
        else if (pop && !keep)
            oob_err_o <= 1'b1;
    end
`endif
endmodule
